// File: rtl/prog_loader_pkg.sv
// prog_loader shared types: load FSM states, UART bit phases, framing sizes.
// LOADER_CHECKSUM_EN adds the CSUM state.
package prog_loader_pkg;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_WORD,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_phase_t;

endpackage

// File: rtl/prog_loader_if.sv
// Instruction-RAM write port (port B) bundle.
// The loader is master; the RAM is slave.
interface prog_loader_if #(
  parameter int ADDR_W = 14
);
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;

  modport master (output we, addr, wdata);
  modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop sync, mid-bit sampling, valid/ferr pulses.
// Start bit is re-checked at half a bit to reject short glitches.
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic            s1_q, s2_q, s3_q;
  rx_phase_t       ph_q, ph_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  // Synchronizer, edge history and receiver state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      ph_q    <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      s1_q    <= rx_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit-phase sequencing and sampling.
  always_comb begin
    ph_d    = ph_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (ph_q)
      R_IDLE: begin
        cnt_d = '0;
        if (s3_q && !s2_q) ph_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          ph_d  = s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) ph_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          valid_d = s2_q;
          ferr_d  = !s2_q;
          ph_d    = R_IDLE;
        end
      end
    endcase
  end

  assign rx_data_o  = sh_q;
  assign rx_valid_o = valid_q;
  assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// UART program loader: length-prefixed LE word stream into imem port B.
// LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          uart_rx,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  prog_loader_if.master imem
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [31:0] MAX_LEN = 32'(1) << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN_ST = S_CSUM;
`else
  localparam state_t FIN_ST = S_DONE;
`endif

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (uart_rx),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .rx_ferr_o (rx_ferr)
  );

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [15:0]       len_full;
  logic [CNT_W-1:0]  cnt_inc;

  assign len_full = {rx_data, len_q[7:0]};
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Load FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next state, word assembly and write-port setup.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          cnt_d   = '0;
          bidx_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (rx_ferr) state_d = S_ERR;
        else if (rx_valid) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_ferr) state_d = S_ERR;
        else if (rx_valid) begin
          len_d = len_full;
          if (len_full == 16'd0) state_d = FIN_ST;
          else if (32'(len_full) > MAX_LEN) state_d = S_ERR;
          else state_d = S_WORD;
        end
      end
      S_WORD: begin
        if (rx_ferr) state_d = S_ERR;
        else if (rx_valid) begin
          bidx_d = bidx_q + 2'd1;
          word_d = {rx_data, word_q[23:8]};
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (bidx_q == 2'(WORD_BYTES - 1)) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = {rx_data, word_q};
          end
        end
      end
      S_WRITE: begin
        cnt_d = cnt_inc;
        if (rx_ferr) state_d = S_ERR;
        else if (32'(cnt_inc) < 32'(len_q)) state_d = S_WORD;
        else state_d = FIN_ST;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_ferr) state_d = S_ERR;
        else if (rx_valid)
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign cpu_hold = busy | err;

  assign imem.we    = we_q;
  assign imem.addr  = addr_q;
  assign imem.wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of byte streams plus
// hand sequences for glitch, length boundary and mid-load reset.
module tb_prog_loader;
  localparam int CPB    = 16;
  localparam int ADDR_W = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic uart_rx = 1'b1;
  logic cpu_hold, busy, done, err;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .uart_rx (uart_rx),
    .cpu_hold(cpu_hold),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .imem    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          n;
    logic [95:0] bs;
    int          bad;
    logic        edone;
    logic        eerr;
    int          enwr;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t tv[8];
  int   nv;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic        we_prev = 1'b0;
  logic        we_long = 1'b0;

  always @(negedge clk) begin
    if (bus.we) begin
      wa.push_back(32'(bus.addr));
      wd.push_back(bus.wdata);
      if (we_prev) we_long = 1'b1;
    end
    we_prev = bus.we;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_bits(int nb);
    repeat (nb * CPB) @(negedge clk);
  endtask

  task automatic send_byte(logic [7:0] b, logic good);
    uart_rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_bits(1);
    end
    uart_rx = good;
    wait_bits(1);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_writes(string nm, int enwr, logic [31:0] d0, logic [31:0] d1);
    chk({nm, ".nwr"}, 32'(wa.size()), 32'(enwr));
    for (int i = 0; i < wa.size() && i < enwr; i++) begin
      chk($sformatf("%s.addr%0d", nm, i), wa[i], 32'(i));
      chk($sformatf("%s.data%0d", nm, i), wd[i], (i == 0) ? d0 : d1);
    end
  endtask

  initial begin
`ifdef LOADER_CHECKSUM_EN
    tv[0] = '{"two", 11, 96'h02_00_13_00_00_00_93_00_10_00_90, -1,
              1'b1, 1'b0, 2, 32'h0000_0013, 32'h0010_0093};
    tv[1] = '{"len0", 3, 96'h00_00_00, -1,
              1'b1, 1'b0, 0, 32'h0, 32'h0};
    tv[3] = '{"recover", 7, 96'h01_00_78_56_34_12_08, -1,
              1'b1, 1'b0, 1, 32'h1234_5678, 32'h0};
    tv[5] = '{"csum_ok", 7, 96'h01_00_13_00_00_00_13, -1,
              1'b1, 1'b0, 1, 32'h0000_0013, 32'h0};
    tv[6] = '{"csum_bad", 7, 96'h01_00_13_00_00_00_12, -1,
              1'b0, 1'b1, 1, 32'h0000_0013, 32'h0};
    nv = 7;
`else
    tv[0] = '{"two", 10, 96'h02_00_13_00_00_00_93_00_10_00, -1,
              1'b1, 1'b0, 2, 32'h0000_0013, 32'h0010_0093};
    tv[1] = '{"len0", 2, 96'h00_00, -1,
              1'b1, 1'b0, 0, 32'h0, 32'h0};
    tv[3] = '{"recover", 6, 96'h01_00_78_56_34_12, -1,
              1'b1, 1'b0, 1, 32'h1234_5678, 32'h0};
    nv = 5;
`endif
    tv[2] = '{"oversize", 2, 96'h01_40, -1,
              1'b0, 1'b1, 0, 32'h0, 32'h0};
    tv[4] = '{"ferr", 5, 96'h01_00_aa_bb_cc, 4,
              1'b0, 1'b1, 0, 32'h0, 32'h0};

    repeat (4) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.hold", 32'(cpu_hold), 32'd0);
    chk("rst.we", 32'(bus.we), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < nv; v++) begin
      wa.delete();
      wd.delete();
      pulse_start();
      for (int i = 0; i < tv[v].n; i++)
        send_byte(tv[v].bs[8*(tv[v].n-1-i) +: 8], (i != tv[v].bad));
      wait_bits(4);
      chk({tv[v].nm, ".done"}, 32'(done), 32'(tv[v].edone));
      chk({tv[v].nm, ".err"}, 32'(err), 32'(tv[v].eerr));
      chk({tv[v].nm, ".busy"}, 32'(busy), 32'd0);
      chk({tv[v].nm, ".hold"}, 32'(cpu_hold), 32'(tv[v].eerr));
      chk_writes(tv[v].nm, tv[v].enwr, tv[v].d0, tv[v].d1);
    end

    // Short low glitch must not produce a byte.
    wa.delete();
    wd.delete();
    pulse_start();
    chk("glitch.busy_rise", 32'(busy), 32'd1);
    uart_rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    uart_rx = 1'b1;
    wait_bits(2);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    wait_bits(4);
    chk("glitch.done", 32'(done), 32'd1);
    chk_writes("glitch", 0, 32'h0, 32'h0);

    // Length exactly 2^ADDR_W is accepted and starts loading words.
    pulse_start();
    send_byte(8'h00, 1'b1);
    send_byte(8'h40, 1'b1);
    wait_bits(2);
    chk("maxlen.busy", 32'(busy), 32'd1);
    chk("maxlen.err", 32'(err), 32'd0);
    chk("maxlen.hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset after two bytes of a word, then reload from address 0.
    pulse_start();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.done", 32'(done), 32'd0);
    chk("rstmid.err", 32'(err), 32'd0);
    chk("rstmid.hold", 32'(cpu_hold), 32'd0);
    chk("rstmid.we", 32'(bus.we), 32'd0);
    chk("rstmid.addr", 32'(bus.addr), 32'd0);
    chk("rstmid.wdata", bus.wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h11, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h44, 1'b1);
`endif
    wait_bits(4);
    chk("reload.done", 32'(done), 32'd1);
    chk_writes("reload", 1, 32'h1122_3344, 32'h0);

    chk("we_one_cycle", 32'(we_long), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

UART program loader that writes a CPU program into instruction memory over a serial link. It is the write side of the instruction-memory interface, whose read side is the fetch unit. The loader holds the CPU in reset while a load is in progress, receives a length-prefixed little-endian word stream, and drives the write port (port B) of the dual-port instruction RAM. It sits between the board UART pin, the instruction RAM and the CPU reset.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200)
- ADDR_W, 14, instruction-RAM word-address width

Ports:
- clk  in  1  system clock; all state on posedge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse that arms a load; ignored while busy
- uart_rx  in  1  serial input; idles high; 8N1, LSB first
- cpu_hold  out  1  high while loading or in error; ANDed into the CPU rst_n path by the top level
- busy  out  1  high from an accepted start until the DONE or ERR state
- done  out  1  high in the DONE state
- err  out  1  high in the ERR state
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  write data

## Operation
- States and transitions:
  - IDLE → LEN_LO on start.
  - LEN_LO → LEN_HI on rx byte.
  - LEN_HI → WORD, or → DONE if len==0, or → ERR if len > 2^ADDR_W.
  - WORD → WRITE on the 4th byte.
  - WRITE → WORD if cnt < len, else → DONE (or → CSUM, see Configuration).
  - DONE/ERR → LEN_LO on start.
- Length: 16-bit, low byte first; unit is 32-bit words.
- Word assembly: the first byte goes to [7:0] and the 4th byte to [31:24]. The byte index is 2 bits and wraps 3→0.
- Write address: word counter cnt, starting at 0 and incremented after each WRITE. It never wraps, because the length check bounds it.
- A framing error (stop bit sampled low) in any non-IDLE/DONE/ERR state → ERR. Bytes received in IDLE, DONE or ERR are discarded.
- cpu_hold = busy | err.
- Reset values:
  - state IDLE
  - cpu_hold 0, busy 0, done 0, err 0
  - imem_we 0, imem_addr 0, imem_wdata 0
  - cnt 0, byte index 0
- Reset mid-load aborts the load immediately. RAM contents written so far remain.

## Timing
- uart_rx passes through a 2-flop synchronizer, giving 2 cycles of latency.
- Start bit: detected on a synchronized falling edge, then re-checked low at CLKS_PER_BIT/2. A glitch shorter than that returns the receiver to idle.
- Data and stop bits are sampled every CLKS_PER_BIT cycles from the start-bit midpoint.
- rx_valid / rx_ferr: one-cycle pulse in the cycle after the stop-bit sample.
- WRITE: entered the cycle after the 4th byte's rx_valid. imem_we, imem_addr and imem_wdata are registered and valid for exactly that one cycle.
- busy rises the cycle after start. done/err rise the cycle after the deciding event.
- start coincident with rx_valid in DONE/ERR: start wins and the byte is discarded.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last WRITE, the FSM enters CSUM and waits for one byte.
  - This byte must equal the XOR of all data bytes, excluding the length bytes. A match goes to DONE; a mismatch goes to ERR.
  - With len==0, the checksum byte is still expected and must be 0x00.
- LOADER_CHECKSUM_EN undefined: no CSUM state and no XOR register. DONE follows the last WRITE directly.

## Structure
- Shared package prog_loader_pkg:
  - state enum
  - UART bit-phase enum
  - LEN_BYTES=2, WORD_BYTES=4
- Sub-module uart_rx (params CLKS_PER_BIT):
  - contains the synchronizer, bit counter, baud counter and shift register
  - outputs rx_data[7:0], rx_valid, rx_ferr
- The top level holds the load FSM, length/count registers, word assembler and optional checksum.

## Test plan
- Load of 2 words: start, bytes 02 00 13 00 00 00 93 00 10 00 → imem_we pulses twice. Writes are addr 0 data 0x00000013, then addr 1 data 0x00100093. done=1, cpu_hold=0 after the second write.
- len=0: start, bytes 00 00 → done=1 with no imem_we (checksum build: also send 00).
- Oversize: len bytes 01 40 (0x4001 with ADDR_W=14) → err=1, cpu_hold=1, no write. A following start plus a valid stream recovers to done.
- Framing error: stop bit driven low on the 3rd data byte → err=1, no write for that word. A glitch of CLKS_PER_BIT/4 on idle uart_rx produces no byte.
- Reset mid-word: assert rst_n=0 after 2 of 4 bytes → all outputs at reset values, state IDLE. A following start reloads from addr 0.
- LOADER_CHECKSUM_EN: stream 01 00 13 00 00 00 with checksum 13 → done. The same stream with checksum 12 → err, with the single write at addr 0 already performed.
